// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// The SERIAL_ADDER_OVF_EN macro (see serial_adder.sv) adds the signed overflow output.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder built from two half adders and an OR of their carries.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic hs1;
   logic hc1;
   logic hc2;

   assign hs1  = a ^ b;
   assign hc1  = a & b;
   assign s    = hs1 ^ cin;
   assign hc2  = hs1 & cin;
   assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one sum bit per clock, LSB first, through a single full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow output.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             overflow,
`endif
   output logic [1:0]       dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // Handshake: start is accepted on any edge where the FSM sits in IDLE or DONE;
   // a/b are sampled only on that edge. done is a one-cycle valid for sum/carry_out.

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic             carry;
   logic             fa_s;
   logic             fa_cout;

   full_adder_bit u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         carry     <= 1'b0;
         sh_a      <= '0;
         sh_b      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         overflow  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sh_a      <= a;
                  sh_b      <= b;
                  carry     <= 1'b0;
                  count     <= '0;
                  carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                  overflow  <= 1'b0;
`endif
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end else begin
                  state     <= IDLE;
               end
            end
            SHIFT: begin
               sum[count] <= fa_s;
               carry      <= fa_cout;
               sh_a       <= sh_a >> 1;
               sh_b       <= sh_b >> 1;
               if (count == LAST) begin
                  // carry still holds the carry into the MSB here
                  carry_out <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                  overflow  <= carry ^ fa_cout;
`endif
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  count     <= count + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle-level busy/done model plus a result scoreboard.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;
   logic [1:0]   dbg_state;
`ifdef SERIAL_ADDER_OVF_EN
   logic         overflow;
`endif

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
`ifdef SERIAL_ADDER_OVF_EN
      .overflow  (overflow),
`endif
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard: {overflow, carry_out, sum}
   logic [W+1:0] exp_q[$];
   int           mdl_cnt  = 0;
   logic         mdl_done = 1'b0;
   logic         mon_on   = 1'b0;

   function automatic logic [W+1:0] ref_add(input logic [W-1:0] xa, input logic [W-1:0] xb);
      logic [W:0] full;
      logic       ovf;
      full = {1'b0, xa} + {1'b0, xb};
      ovf  = (xa[W-1] == xb[W-1]) && (full[W-1] != xa[W-1]);
      return {ovf, full[W], full[W-1:0]};
   endfunction

   // acceptance model: start is taken whenever no shift is in flight
   always @(posedge clk) begin
      if (!rst_n) begin
         mdl_cnt  = 0;
         mdl_done = 1'b0;
         exp_q.delete();
      end else if (mdl_cnt == 0) begin
         mdl_done = 1'b0;
         if (start) begin
            exp_q.push_back(ref_add(a, b));
            mdl_cnt = W;
         end
      end else begin
         mdl_done = (mdl_cnt == 1);
         mdl_cnt  = mdl_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         logic [W+1:0] e;
         check_val("busy", 32'(busy), 32'(mdl_cnt != 0));
         check_val("done", 32'(done), 32'(mdl_done));
         if (done) begin
            if (exp_q.size() == 0) begin
               check_val("done_without_expect", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check_val("sum", 32'(sum), 32'(e[W-1:0]));
               check_val("carry_out", 32'(carry_out), 32'(e[W]));
               check_val("state_done", 32'(dbg_state), 32'd2);
`ifdef SERIAL_ADDER_OVF_EN
               check_val("overflow", 32'(overflow), 32'(e[W+1]));
`endif
            end
         end
      end
   end

   // driver: call on a negedge; returns on the negedge after done (or timeout)
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
      int busy_cycles;
      int lat;
      start = 1'b1;
      a     = xa;
      b     = xb;
      @(negedge clk);
      start = 1'b0;
      a     = $urandom_range(0, 255);
      b     = $urandom_range(0, 255);
      busy_cycles = 0;
      lat = 1;
      while (!done && lat < 30) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         lat++;
      end
      check_val("done_seen", 32'(done), 32'd1);
      check_val("latency", 32'(lat), 32'(W + 1));
      check_val("busy_cycles", 32'(busy_cycles), 32'(W));
      @(negedge clk);
   endtask

   initial begin
      int n_done;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_sum", 32'(sum), 32'd0);
      check_val("rst_carry_out", 32'(carry_out), 32'd0);
      check_val("rst_state", 32'(dbg_state), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check_val("rst_overflow", 32'(overflow), 32'd0);
`endif
      rst_n  = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);

      // directed corner operands
      run_op(8'h00, 8'h00);
      run_op(8'hFF, 8'h01);
      run_op(8'h7F, 8'h01);
      run_op(8'h80, 8'h80);

      // start held high: back-to-back, with a mid-shift operand change
      start  = 1'b1;
      a      = 8'h12;
      b      = 8'h34;
      n_done = 0;
      for (int i = 1; i <= 3 * (W + 1); i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            check_val("b2b_sum", 32'(sum), 32'h46);
         end
         if (i == 4) a = 8'hFF;
         if (i == 5) a = 8'h12;
      end
      start = 1'b0;
      check_val("b2b_count", 32'(n_done), 32'd3);
      repeat (2) @(negedge clk);

      // reset on the 4th shift edge
      start = 1'b1;
      a     = 8'hAA;
      b     = 8'h55;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_done", 32'(done), 32'd0);
      check_val("mid_rst_sum", 32'(sum), 32'd0);
      check_val("mid_rst_state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;
      repeat (W + 2) @(negedge clk);
      run_op(8'hAA, 8'h55);

      // random operands
      for (int i = 0; i < 20; i++) begin
         run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      end

      repeat (3) @(negedge clk);
      check_val("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
